// File: rtl/video_sync_timing_ctrl.sv
// ---------------------------------------------------------------------------
// video_sync_timing_ctrl
//
// Raster timing controller for one video channel. A horizontal pixel counter
// and a vertical line counter each walk through the phases
// ACTIVE -> FRONT -> SYNC -> BACK. Sync and blank are decoded from these
// phases and drive the sync/blank output stage.
//
// Ports
//   blif_clk_net    in   clock, rising edge
//   blif_reset_net  in   asynchronous active-low reset
//   en              in   pixel advance enable
//   sync_clr        in   synchronous restart to pixel 0, line 0
//   hcnt            out  pixel index, 0..H_TOTAL-1
//   vcnt            out  line index, 0..V_TOTAL-1
//   hsync / vsync   out  active-high syncs (registered)
//   csync           out  hsync ^ vsync (registered)
//   blank           out  high outside the active region (registered)
//   line_end        out  combinational: en & hcnt==H_TOTAL-1
//   frame_end       out  combinational: line_end & vcnt==V_TOTAL-1
//   hphase / vphase out  phase state: 0 ACT, 1 FP, 2 SYN, 3 BP
// ---------------------------------------------------------------------------
module video_sync_timing_ctrl #(
  parameter int H_ACT = 640,
  parameter int H_FP  = 16,
  parameter int H_SYN = 96,
  parameter int H_BP  = 48,
  parameter int V_ACT = 480,
  parameter int V_FP  = 10,
  parameter int V_SYN = 2,
  parameter int V_BP  = 33,
  parameter int CW    = 11
) (
  input  logic          blif_clk_net,
  input  logic          blif_reset_net,
  input  logic          en,
  input  logic          sync_clr,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          blank,
  output logic          line_end,
  output logic          frame_end,
  output logic [1:0]    hphase,
  output logic [1:0]    vphase
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYN + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } phase_t;

  // Control semantics (no handshake): en qualifies every advance; with en=0
  // all registers hold and both strobes are 0. sync_clr wins over en and over
  // any wrap on the same edge, while the strobes still show the pre-clear
  // position during that cycle.

  phase_t        h_state, h_state_nxt;
  phase_t        v_state, v_state_nxt;
  logic [CW-1:0] h_loc, h_loc_nxt;     // position inside the current h phase
  logic [CW-1:0] v_loc, v_loc_nxt;     // position inside the current v phase
  logic [CW-1:0] hcnt_nxt, vcnt_nxt;

  function automatic logic [CW-1:0] h_last(input phase_t p);
    case (p)
      PH_ACT:  h_last = CW'(H_ACT - 1);
      PH_FP:   h_last = CW'(H_FP - 1);
      PH_SYN:  h_last = CW'(H_SYN - 1);
      default: h_last = CW'(H_BP - 1);
    endcase
  endfunction

  function automatic logic [CW-1:0] v_last(input phase_t p);
    case (p)
      PH_ACT:  v_last = CW'(V_ACT - 1);
      PH_FP:   v_last = CW'(V_FP - 1);
      PH_SYN:  v_last = CW'(V_SYN - 1);
      default: v_last = CW'(V_BP - 1);
    endcase
  endfunction

  // BP wraps back to ACT through the natural 2-bit rollover.
  function automatic phase_t next_phase(input phase_t p);
    next_phase = phase_t'(p + 2'd1);
  endfunction

  assign line_end  = en & (hcnt == H_LAST);
  assign frame_end = line_end & (vcnt == V_LAST);
  assign hphase    = h_state;
  assign vphase    = v_state;

  always_comb begin
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    h_loc_nxt   = h_loc;
    v_loc_nxt   = v_loc;
    hcnt_nxt    = hcnt;
    vcnt_nxt    = vcnt;
    if (sync_clr) begin
      h_state_nxt = PH_ACT;
      v_state_nxt = PH_ACT;
      h_loc_nxt   = '0;
      v_loc_nxt   = '0;
      hcnt_nxt    = '0;
      vcnt_nxt    = '0;
    end else if (en) begin
      if (h_loc == h_last(h_state)) begin
        h_loc_nxt   = '0;
        h_state_nxt = next_phase(h_state);
      end else begin
        h_loc_nxt = h_loc + CW'(1);
      end
      hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + CW'(1);

      if (line_end) begin
        if (v_loc == v_last(v_state)) begin
          v_loc_nxt   = '0;
          v_state_nxt = next_phase(v_state);
        end else begin
          v_loc_nxt = v_loc + CW'(1);
        end
        vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end
    end
  end

  // Sync/blank are decoded from the next state so that, once registered,
  // they line up with the counters and phases shown on the same cycle.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      h_state <= PH_ACT;
      v_state <= PH_ACT;
      h_loc   <= '0;
      v_loc   <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      csync   <= 1'b0;
      blank   <= 1'b0;
    end else begin
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      h_loc   <= h_loc_nxt;
      v_loc   <= v_loc_nxt;
      hcnt    <= hcnt_nxt;
      vcnt    <= vcnt_nxt;
      hsync   <= (h_state_nxt == PH_SYN);
      vsync   <= (v_state_nxt == PH_SYN);
      csync   <= (h_state_nxt == PH_SYN) ^ (v_state_nxt == PH_SYN);
      blank   <= (h_state_nxt != PH_ACT) | (v_state_nxt != PH_ACT);
    end
  end

endmodule

// File: tb/tb_video_sync_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_sync_timing_ctrl
//
// Directed bench for video_sync_timing_ctrl with a small raster:
// H = 8/2/3/2 (15 pixels), V = 4/1/2/1 (8 lines). A position model (mh, mv)
// predicts every output from the raster position alone; phases are derived
// from position ranges rather than phase-local counters.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_video_sync_timing_ctrl;

  localparam int CW = 4;

  // ---- clock / reset ------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic [CW-1:0] hcnt, vcnt;
  logic          hsync, vsync, csync, blank, line_end, frame_end;
  logic [1:0]    hphase, vphase;

  always #5 clk = ~clk;

  video_sync_timing_ctrl #(
    .H_ACT(8), .H_FP(2), .H_SYN(3), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYN(2), .V_BP(1),
    .CW(CW)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .en             (en),
    .sync_clr       (sync_clr),
    .hcnt           (hcnt),
    .vcnt           (vcnt),
    .hsync          (hsync),
    .vsync          (vsync),
    .csync          (csync),
    .blank          (blank),
    .line_end       (line_end),
    .frame_end      (frame_end),
    .hphase         (hphase),
    .vphase         (vphase)
  );

  // ---- scoreboard state ---------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int mh = 0;        // model pixel index
  int mv = 0;        // model line index
  int le_cnt = 0;    // observed line_end pulses
  int fe_cnt = 0;    // observed frame_end pulses

  function automatic int ph_h(input int h);
    if (h < 8)       return 0;
    else if (h < 10) return 1;
    else if (h < 13) return 2;
    return 3;
  endfunction

  function automatic int ph_v(input int v);
    if (v < 4)      return 0;
    else if (v < 5) return 1;
    else if (v < 7) return 2;
    return 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t pos=%0d,%0d)", tag, obs, exp, $time, mh, mv);
    end
  endtask

  task automatic check_outputs(input logic e);
    int   hp, vp;
    logic exp_hs, exp_vs, exp_le, exp_fe;
    hp     = ph_h(mh);
    vp     = ph_v(mv);
    exp_hs = (hp == 2);
    exp_vs = (vp == 2);
    exp_le = e && (mh == 14);
    exp_fe = exp_le && (mv == 7);
    chk("hcnt",      hcnt,      mh);
    chk("vcnt",      vcnt,      mv);
    chk("hphase",    hphase,    hp);
    chk("vphase",    vphase,    vp);
    chk("hsync",     hsync,     exp_hs);
    chk("vsync",     vsync,     exp_vs);
    chk("csync",     csync,     exp_hs ^ exp_vs);
    chk("blank",     blank,     (hp != 0) || (vp != 0));
    chk("line_end",  line_end,  exp_le);
    chk("frame_end", frame_end, exp_fe);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hcnt"},   hcnt,   0);
    chk({tag, "_vcnt"},   vcnt,   0);
    chk({tag, "_hphase"}, hphase, 0);
    chk({tag, "_vphase"}, vphase, 0);
    chk({tag, "_hsync"},  hsync,  0);
    chk({tag, "_vsync"},  vsync,  0);
    chk({tag, "_csync"},  csync,  0);
    chk({tag, "_blank"},  blank,  0);
  endtask

  // ---- driver: one clock cycle with full output check ---------------------
  task automatic cycle(input logic e, input logic clr);
    @(negedge clk);
    en       = e;
    sync_clr = clr;
    #1;
    check_outputs(e);
    if (line_end)  le_cnt++;
    if (frame_end) fe_cnt++;
    @(posedge clk);
    if (clr) begin
      mh = 0;
      mv = 0;
    end else if (e) begin
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  // ---- watchdog -----------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- directed sequence --------------------------------------------------
  initial begin
    int enabled;
    int iters;
    logic e;

    // Reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_values("reset");
    chk("reset_line_end",  line_end,  0);
    chk("reset_frame_end", frame_end, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First line: one line_end at hcnt=14, vcnt moves to 1
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0);
    #1;
    chk("line1_le_count", le_cnt, 1);
    chk("line1_hcnt", hcnt, 0);
    chk("line1_vcnt", vcnt, 1);

    // Rest of the frame: 120 enabled cycles total
    for (int i = 0; i < 105; i++) cycle(1'b1, 1'b0);
    #1;
    chk("frame_le_count", le_cnt, 8);
    chk("frame_fe_count", fe_cnt, 1);
    chk("frame_wrap_hcnt", hcnt, 0);
    chk("frame_wrap_vcnt", vcnt, 0);

    // Random enable over two frames (240 enabled cycles)
    enabled = 0;
    iters   = 0;
    while (enabled < 240 && iters < 2000) begin
      e = 1'($urandom_range(0, 1));
      cycle(e, 1'b0);
      if (e) enabled++;
      iters++;
    end
    #1;
    chk("random_end_hcnt", hcnt, 0);
    chk("random_end_vcnt", vcnt, 0);
    chk("random_fe_count", fe_cnt, 3);

    // sync_clr at the last pixel of the frame with en=1
    for (int i = 0; i < 119; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    #1;
    chk("clr_hcnt",   hcnt,   0);
    chk("clr_vcnt",   vcnt,   0);
    chk("clr_hphase", hphase, 0);
    chk("clr_vphase", vphase, 0);

    // sync_clr mid-line with en=0
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    #1;
    chk("clr_en0_hcnt", hcnt, 0);
    chk("clr_en0_vcnt", vcnt, 0);

    // Asynchronous reset mid-SYN (hcnt=11)
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0);
    @(negedge clk);
    en       = 1'b0;
    sync_clr = 1'b0;
    #1;
    chk("pre_areset_hcnt",  hcnt,  11);
    chk("pre_areset_hsync", hsync, 1);
    #2 rst_n = 1'b0;   // 2 ns before the next rising edge
    #1;
    check_reset_values("areset");
    mh = 0;
    mv = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Counting resumes from (0,0)
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
